// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// State encoding, counter width and word geometry.
package dmem_pkg;

  localparam int CNT_W      = 4;
  localparam int WORD_BYTES = 4;
  localparam int OFF_W      = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_e;

  function automatic logic misaligned(
    input logic [OFF_W-1:0] lo
  );
    return lo != '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM.
// Registered read port, no reset on contents or output.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[idx] <= wdata;
    end
    rdata <= r_mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait
// states, registered response and a stall toward the hazard unit.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic             r_write;
  logic             r_mis;
  logic [AW-1:0]    r_idx;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic             w_accept;
  logic [AW-1:0]    w_req_idx;
  logic [AW-1:0]    w_ram_idx;
  logic             w_ram_we;
  logic [31:0]      w_ram_rdata;
  logic             w_unused_addr;

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_req_idx = req_addr[OFF_W +: AW];

  // Upper address bits wrap away by design.
  assign w_unused_addr = ^req_addr[31:AW+OFF_W];

  // The RAM read register must hold the target word during ACCESS,
  // so while idle it is steered by the live request address.
  assign w_ram_idx = (r_state == ST_IDLE) ? w_req_idx : r_idx;
  assign w_ram_we  = (r_state == ST_ACCESS) && r_write && !r_mis;

  dmem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (w_ram_we),
    .idx   (w_ram_idx),
    .wdata (r_wdata),
    .rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_mis   <= misaligned(req_addr[OFF_W-1:0]);
      r_idx   <= w_req_idx;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (r_state == ST_ACCESS) begin
        r_rdata <= (r_write || r_mis) ? 32'd0 : w_ram_rdata;
        r_err   <= r_mis;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_next = ST_ACCESS;
          end else begin
            w_next    = ST_WAIT;
            w_cnt_nxt = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_next = ST_ACCESS;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign stall_o    = (req_valid && r_state == ST_IDLE)
                   || (r_state == ST_WAIT)
                   || (r_state == ST_ACCESS);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: scoreboard on the default build,
// direct checks on a zero-wait-state build.
module tb_dmem_responder;

  localparam int WAIT_A = 2;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_valid, a_write;
  logic [31:0] a_addr, a_wdata;
  logic        a_ready, a_rvalid, a_err, a_stall;
  logic [31:0] a_rdata;

  logic        b_valid, b_write;
  logic [31:0] b_addr, b_wdata;
  logic        b_ready, b_rvalid, b_err, b_stall;
  logic [31:0] b_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    time         due;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (WAIT_A)
  ) u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (a_valid),
    .req_write  (a_write),
    .req_addr   (a_addr),
    .req_wdata  (a_wdata),
    .req_ready  (a_ready),
    .resp_valid (a_rvalid),
    .resp_rdata (a_rdata),
    .resp_err   (a_err),
    .stall_o    (a_stall)
  );

  dmem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (0)
  ) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (b_valid),
    .req_write  (b_write),
    .req_addr   (b_addr),
    .req_wdata  (b_wdata),
    .req_ready  (b_ready),
    .resp_valid (b_rvalid),
    .resp_rdata (b_rdata),
    .resp_err   (b_err),
    .stall_o    (b_stall)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the default build.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && a_rvalid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got rdata %h err %b", a_rdata, a_err);
      end else begin
        e = q.pop_front();
        chk("resp_rdata", a_rdata, e.rdata);
        chk("resp_err", {31'd0, a_err}, {31'd0, e.err});
        chk("resp_latency", 32'($time), 32'(e.due));
        chk("ready_in_resp", {31'd0, a_ready}, 32'd0);
        chk("stall_in_resp", {31'd0, a_stall}, 32'd0);
      end
    end
  end

  task automatic req_a(input string tag, input logic w,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
    int  guard;
    int  st;
    int  rdy;
    time t_acc;
    @(negedge clk);
    a_valid = 1'b1;
    a_write = w;
    a_addr  = addr;
    a_wdata = wd;
    guard = 0;
    while (!a_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
      a_valid = 1'b0;
      return;
    end
    t_acc = $time;
    q.push_back('{exp_rd, exp_err, t_acc + (WAIT_A + 2) * 10});
    @(negedge clk);
    // Scramble the request bus while busy; it must be ignored.
    a_valid = 1'b0;
    a_write = ~w;
    a_addr  = ~addr;
    a_wdata = ~wd;
    st = 0;
    rdy = 0;
    guard = 0;
    while (!a_rvalid && guard < 50) begin
      st += int'(a_stall);
      rdy += int'(a_ready);
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      chk({tag, "_resp_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_stall_cycles"}, 32'(st), 32'(WAIT_A + 1));
    chk({tag, "_ready_busy"}, 32'(rdy), 32'd0);
  endtask

  task automatic req_b(input string tag, input logic w,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd);
    int  guard;
    int  st;
    time t_acc;
    @(negedge clk);
    b_valid = 1'b1;
    b_write = w;
    b_addr  = addr;
    b_wdata = wd;
    guard = 0;
    while (!b_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    t_acc = $time;
    @(negedge clk);
    b_valid = 1'b0;
    st = 0;
    guard = 0;
    while (!b_rvalid && guard < 50) begin
      st += int'(b_stall);
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      chk({tag, "_resp_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_latency"}, 32'($time), 32'(t_acc + 20));
    chk({tag, "_stall_cycles"}, 32'(st), 32'd1);
    chk({tag, "_rdata"}, b_rdata, exp_rd);
    chk({tag, "_err"}, {31'd0, b_err}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_write = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);
    chk("rst_stall", {31'd0, a_stall}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd1);
    rst = 1'b0;

    // Seed words, then reset: contents must survive.
    req_a("seed10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    req_a("seed00", 1'b1, 32'h00, 32'hA5A50000, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    req_a("t1_load10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    chk("t1_hold_rdata", a_rdata, 32'hDEADBEEF);

    req_a("t2_store20", 1'b1, 32'h20, 32'h12345678, 32'd0, 1'b0);
    req_a("t2_load20", 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);

    req_a("t3_load22", 1'b0, 32'h22, 32'h0, 32'd0, 1'b1);
    @(negedge clk);
    chk("t3_hold_err", {31'd0, a_err}, 32'd1);
    req_a("t3_store23", 1'b1, 32'h23, 32'hFFFF0000, 32'd0, 1'b1);
    req_a("t3_reload20", 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);

    req_a("t4_wrap400", 1'b0, 32'h400, 32'h0, 32'hA5A50000, 1'b0);
    req_a("t4_wrap_hi", 1'b0, 32'hFFFF_FC10, 32'h0, 32'hDEADBEEF, 1'b0);

    req_a("t5_seed30", 1'b1, 32'h30, 32'h11112222, 32'd0, 1'b0);
    @(negedge clk);
    a_valid = 1'b1;
    a_write = 1'b1;
    a_addr  = 32'h30;
    a_wdata = 32'h33334444;
    @(negedge clk);
    a_valid = 1'b0;
    chk("t5_in_wait_stall", {31'd0, a_stall}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_idle_ready", {31'd0, a_ready}, 32'd1);
    chk("t5_no_rvalid", {31'd0, a_rvalid}, 32'd0);
    repeat (5) @(negedge clk);
    req_a("t5_load30", 1'b0, 32'h30, 32'h0, 32'h11112222, 1'b0);

    req_b("t6_store08", 1'b1, 32'h08, 32'hCAFEF00D, 32'd0);
    req_b("t6_load08", 1'b0, 32'h08, 32'h0, 32'hCAFEF00D);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
